// File: rtl/arctan_lut_arbiter.sv
// ---------------------------------------------------------------------------
// arctan_lut_arbiter
//
// Round-robin arbiter that shares one arctan ROM lookup port between N_REQ
// phase-angle requesters. Every requester owns a one-deep holding register.
// One lookup is issued per cycle. Each ROM result is returned tagged with the
// id of the requester that asked for it.
//
// Handshake rule: a transfer on requester i happens on a rising clk edge where
// req_valid[i] & req_ready[i] are both high. req_ready depends only on
// registered state and ce, never on req_valid. rsp_valid is a one-cycle
// strobe with no back-pressure.
//
// Optional feature: define ARCTAN_ARB_STALL_CNT_EN to build the stall counter.
// Without it, stall_cnt is tied to zero.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   ce             clock enable for accept/grant logic
//   req_valid      per-requester operand valid
//   req_addr       packed operands, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready      per-requester ready
//   lut_addr       registered ROM address
//   lut_valid      registered ROM read strobe
//   lut_dout       ROM data
//   lut_dout_valid ROM data valid
//   rsp_data       registered arctan result
//   rsp_id         registered requester index of rsp_data
//   rsp_valid      response strobe, one cycle per result
//   seq_err        sticky: a tagged slot returned without lut_dout_valid
//   stall_cnt      ce cycles with a pending request that was not granted
// ---------------------------------------------------------------------------
module arctan_lut_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int LUT_LAT = 1,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]       lut_addr,
    output logic                    lut_valid,
    input  logic [DATA_W-1:0]       lut_dout,
    input  logic                    lut_dout_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_valid,
    output logic                    seq_err,
    output logic [31:0]             stall_cnt
);

    // Request side state
    logic [N_REQ-1:0]  pend_q, pend_d;
    logic [ADDR_W-1:0] hold_q [N_REQ];
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    // Grant decode
    logic [N_REQ-1:0]  gnt;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_id;
    logic [N_REQ-1:0]  hs;

    // ROM issue stage; lut_id_q travels with lut_valid_q into the tag pipe
    logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
    logic              lut_valid_q;
    logic [ID_W-1:0]   lut_id_q;

    // Tag pipe, aligned with the ROM return at its last stage
    logic [LUT_LAT-1:0] tag_v_q;
    logic [ID_W-1:0]    tag_id_q [LUT_LAT];
    logic               tag_v_out;
    logic [ID_W-1:0]    tag_id_out;

    // Response stage
    logic [DATA_W-1:0] rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_valid_q;
    logic              seq_err_q;

    // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!gnt_any && pend_q[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
        if (!ce) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    // A granted slot is emptied this edge, so it may be refilled at once;
    // this is what lets a lone requester sustain one lookup per cycle.
    assign req_ready = {N_REQ{ce}} & (~pend_q | gnt);
    assign hs        = req_valid & req_ready;
    assign pend_d    = (pend_q & ~gnt) | hs;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lut_addr_d = lut_addr_q;
        if (gnt_any) begin
            lut_addr_d = hold_q[gnt_id];
            rr_ptr_d   = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            rr_ptr_q    <= '0;
            lut_addr_q  <= '0;
            lut_valid_q <= 1'b0;
            lut_id_q    <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            pend_q      <= pend_d;
            rr_ptr_q    <= rr_ptr_d;
            lut_addr_q  <= lut_addr_d;
            lut_valid_q <= gnt_any;
            if (gnt_any) begin
                lut_id_q <= gnt_id;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (hs[i]) begin
                    hold_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // The ROM ignores ce, so the tag pipe shifts every cycle to stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            for (int k = 0; k < LUT_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_v_q[0]  <= lut_valid_q;
            tag_id_q[0] <= lut_id_q;
            for (int k = 1; k < LUT_LAT; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    assign tag_v_out  = tag_v_q[LUT_LAT-1];
    assign tag_id_out = tag_id_q[LUT_LAT-1];

    // ROM returns with no matching tag (e.g. stale after reset) are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= tag_v_out;
            if (tag_v_out) begin
                rsp_data_q <= lut_dout;
                rsp_id_q   <= tag_id_out;
            end
            if (tag_v_out && !lut_dout_valid) begin
                seq_err_q <= 1'b1;
            end
        end
    end

`ifdef ARCTAN_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (ce && (|(pend_q & ~gnt)) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

    assign lut_addr  = lut_addr_q;
    assign lut_valid = lut_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_arctan_lut_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for arctan_lut_arbiter: directed vectors, ROM model
// mem[a] = a[15:0], expected responses queued in grant order and compared by
// an independent monitor.
// ---------------------------------------------------------------------------
module tb_arctan_lut_arbiter;

  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int IW = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ce    = 1'b0;

  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   lut_addr;
  logic            lut_valid;
  logic [DW-1:0]   lut_dout = '0;
  logic            lut_dout_valid = 1'b0;
  logic [DW-1:0]   rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            rsp_valid;
  logic            seq_err;
  logic [31:0]     stall_cnt;

  logic rom_drop = 1'b0;
  logic rom_inj  = 1'b0;

  arctan_lut_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LUT_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .lut_addr(lut_addr), .lut_valid(lut_valid),
    .lut_dout(lut_dout), .lut_dout_valid(lut_dout_valid),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_valid(rsp_valid),
    .seq_err(seq_err), .stall_cnt(stall_cnt)
  );

  // ROM model, one cycle latency, not reset (so stale returns are possible)
  always @(posedge clk) begin
    lut_dout       <= lut_addr[15:0];
    lut_dout_valid <= (lut_valid & ~rom_drop) | rom_inj;
  end

  // scoreboard
  logic [IW+DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] data);
    exp_q.push_back({2'(id), data});
  endtask

  // monitor
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual id=%0d data=%0h expected=none", rsp_id, rsp_data);
      end else begin
        logic [IW+DW-1:0] e;
        e = exp_q.pop_front();
        check("rsp_id_data", {46'd0, rsp_id, rsp_data}, {46'd0, e});
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ce    = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // 1: single requester, 4 back-to-back operands
  task automatic test_single();
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    set_addr(0, 18'h00100);
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 16'h0100 + 16'(i));
      @(negedge clk);
      check("single_ready", 64'(req_ready[0]), 64'd1);
      if (i == 3) check("single_latency_early", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
      set_addr(0, 18'h00101 + 18'(i));
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("single_b2b_valid", 64'(rsp_valid), 64'd1);
    end
    wait_drain("single_drain");
  endtask

  // 2: all four continuously valid, three operands each
  task automatic test_rr();
    int cnt[N];
    logic [N-1:0] hs;
    int guard;
    do_reset();
    for (int n = 0; n < 3; n++)
      for (int i = 0; i < N; i++)
        push_exp(i, 16'(i * 4096 + n));
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      req_valid[i] = 1'b1;
      set_addr(i, 18'(i * 4096));
    end
    guard = 0;
    while (req_valid != '0 && guard < 40) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          cnt[i]++;
          if (cnt[i] == 3) req_valid[i] = 1'b0;
          else set_addr(i, 18'(i * 4096 + cnt[i]));
        end
      end
      guard++;
    end
    check("rr_all_accepted", 64'(req_valid), 64'd0);
    wait_drain("rr_drain");
  endtask

  // 3: ce low for 5 cycles with requester 2 pending
  task automatic test_ce();
    @(posedge clk); #1;
    req_valid[2] = 1'b1;
    set_addr(2, 18'h2A5A5);
    push_exp(2, 16'hA5A5);
    @(posedge clk); #1;
    req_valid = '0;
    ce = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("ce_low_lut_valid", 64'(lut_valid), 64'd0);
      check("ce_low_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    ce = 1'b1;
    @(negedge clk);
    check("ce_back_ready", 64'(req_ready), 64'hF);
    @(negedge clk);
    check("ce_grant_valid", 64'(lut_valid), 64'd1);
    check("ce_grant_addr", 64'(lut_addr), 64'h2A5A5);
    @(negedge clk);
    check("ce_rsp_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("ce_rsp_lat", 64'(rsp_valid), 64'd1);
    wait_drain("ce_drain");
  endtask

  // 4: reset with two lookups in flight, then a stale ROM return
  task automatic test_reset_mid();
    @(posedge clk); #1;
    req_valid = 4'b0011;
    set_addr(0, 18'h00011);
    set_addr(1, 18'h00022);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("inflight_lut_valid", 64'(lut_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_lut_valid", 64'(lut_valid), 64'd0);
    check("rst_lut_addr", 64'(lut_addr), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rom_inj = 1'b1;
    @(posedge clk); #1;
    rom_inj = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    check("post_rst_seq_err", 64'(seq_err), 64'd0);
  endtask

  // 5: ROM drops valid for one tagged slot
  task automatic test_seq_err();
    rom_drop = 1'b1;
    @(posedge clk); #1;
    req_valid[3] = 1'b1;
    set_addr(3, 18'h3BEEF);
    push_exp(3, 16'hBEEF);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    rom_drop = 1'b0;
    @(negedge clk);
    check("seq_err_set", 64'(seq_err), 64'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    set_addr(1, 18'h01234);
    push_exp(1, 16'h1234);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain("seq_err_drain");
    check("seq_err_sticky", 64'(seq_err), 64'd1);
    do_reset();
    @(negedge clk);
    check("seq_err_cleared", 64'(seq_err), 64'd0);
  endtask

  // 6: four requesters continuously pending for 10 ce cycles
  task automatic test_stall();
    do_reset();
    for (int g = 0; g < 14; g++)
      push_exp(g % N, 16'h0A00 + 16'(g % N));
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_addr(i, 18'h00A00 + 18'(i));
    req_valid = '1;
    repeat (11) @(posedge clk);
    #1;
    ce = 1'b0;
    req_valid = '0;
    @(negedge clk);
`ifdef ARCTAN_ARB_STALL_CNT_EN
    check("stall_cnt_10", 64'(stall_cnt), 64'd10);
`else
    check("stall_cnt_off", 64'(stall_cnt), 64'd0);
`endif
    repeat (3) @(negedge clk);
    check("stall_ce_low_lut_valid", 64'(lut_valid), 64'd0);
    @(posedge clk); #1;
    ce = 1'b1;
    wait_drain("stall_drain");
`ifdef ARCTAN_ARB_STALL_CNT_EN
    check("stall_cnt_final", 64'(stall_cnt), 64'd13);
`else
    check("stall_cnt_final_off", 64'(stall_cnt), 64'd0);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_lut_valid", 64'(lut_valid), 64'd0);
    check("reset_lut_addr", 64'(lut_addr), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_rsp_id", 64'(rsp_id), 64'd0);
    check("reset_seq_err", 64'(seq_err), 64'd0);
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    check("reset_ready_ce0", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ce    = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(req_ready), 64'hF);

    test_single();
    test_rr();
    test_ce();
    test_reset_mid();
    test_seq_err();
    test_stall();

    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
